// File: rtl/dct_coef_collector_if.sv
// Coefficient capture and output stream bundle for the DCT coefficient collector.
// The collector drives through master; the source and consumer side use slave.
interface dct_coef_collector_if #(
   parameter int IN_W  = 18,
   parameter int OUT_W = 16,
   parameter int DEPTH = 8
) ();
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic signed [IN_W-1:0]  coef_in;
   logic                    coef_done;
   logic signed [OUT_W-1:0] m_data;
   logic [2:0]              m_idx;
   logic                    m_last;
   logic                    m_valid;
   logic                    m_ready;
   logic [LVL_W-1:0]        level;
   logic                    overflow;

   modport master (
      input  coef_in, coef_done, m_ready,
      output m_data, m_idx, m_last, m_valid, level, overflow
   );

   modport slave (
      output coef_in, coef_done, m_ready,
      input  m_data, m_idx, m_last, m_valid, level, overflow
   );
endinterface

// File: rtl/dct_coef_collector.sv
// Captures DCT coefficients on the done strobe, tags frame position, rounds/scales/
// saturates to OUT_W bits and buffers them in a FIFO behind a valid/ready handshake.
module dct_coef_collector #(
   parameter int IN_W  = 18,
   parameter int OUT_W = 16,
   parameter int SHIFT = 2,
   parameter int NCOEF = 4,
   parameter int DEPTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   dct_coef_collector_if.master bus
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int EXT_W  = ((IN_W > OUT_W) ? IN_W : OUT_W) + SHIFT + 2;
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic signed [EXT_W-1:0] RND     = (SHIFT > 0) ? (EXT_W'(1) << RND_SH) : '0;
   localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [2:0]              IDX_LAST = 3'(NCOEF - 1);
   localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(DEPTH);

   // Round half up, floor-shift, then clamp into the signed OUT_W range.
   function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [IN_W-1:0] x);
      logic signed [EXT_W-1:0] ext;
      ext = EXT_W'(x);
      ext = (ext + RND) >>> SHIFT;
      if (ext > SAT_MAX) begin
         return SAT_MAX[OUT_W-1:0];
      end else if (ext < SAT_MIN) begin
         return SAT_MIN[OUT_W-1:0];
      end
      return ext[OUT_W-1:0];
   endfunction

   logic signed [OUT_W-1:0] data_mem [DEPTH];
   logic [2:0]              idx_mem  [DEPTH];
   logic                    last_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic [2:0]       cap_idx;
   logic             overflow;

   // Stage 0: combinational scaling of the strobed coefficient.
   logic signed [OUT_W-1:0] scaled_p0;
   logic                    vld_p0;
   logic                    nonempty, pop, push;

   assign scaled_p0 = round_sat(bus.coef_in);
   assign vld_p0    = bus.coef_done;
   assign nonempty  = (count != '0);
   assign pop       = nonempty & bus.m_ready;
   assign push      = vld_p0 & ((count < CNT_FULL) | pop);

   // Stage 1: FIFO storage (data path, never reset).
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= scaled_p0;
         idx_mem[wr_ptr]  <= cap_idx;
         last_mem[wr_ptr] <= (cap_idx == IDX_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         cap_idx  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (vld_p0 && !push) overflow <= 1'b1;
         // Frame position advances on drops too, keeping tags aligned with the source.
         if (vld_p0) cap_idx <= (cap_idx == IDX_LAST) ? 3'd0 : cap_idx + 3'd1;
      end
   end

   // Head entry is masked while empty so stale storage never shows on the bus.
   assign bus.m_valid  = nonempty;
   assign bus.m_data   = nonempty ? data_mem[rd_ptr] : '0;
   assign bus.m_idx    = nonempty ? idx_mem[rd_ptr]  : 3'd0;
   assign bus.m_last   = nonempty ? last_mem[rd_ptr] : 1'b0;
   assign bus.level    = count;
   assign bus.overflow = overflow;
endmodule

// File: tb/tb_dct_coef_collector.sv
// Randomised and directed bench for dct_coef_collector against a queue-based model.
module tb_dct_coef_collector;
   localparam int IN_W  = 18;
   localparam int OUT_W = 16;
   localparam int SHIFT = 2;
   localparam int NCOEF = 4;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dct_coef_collector_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

   dct_coef_collector #(
      .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .NCOEF(NCOEF), .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scaling computed with plain integer division and clamping.
   function automatic longint ref_scale(input longint x);
      longint d, n, q, hi, lo;
      d  = longint'(1) << SHIFT;
      n  = x + ((SHIFT > 0) ? d / 2 : 0);
      q  = n / d;
      if ((n % d) != 0 && n < 0) q = q - 1;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -(longint'(1) << (OUT_W - 1));
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      return q;
   endfunction

   typedef struct {
      longint data;
      int     idx;
      bit     last;
   } ent_t;

   ent_t mq[$];
   int   m_cap  = 0;
   bit   m_ovf  = 1'b0;
   bit   cmp_en = 1'b0;

   always @(posedge clk) begin
      bit do_pop, do_push;
      if (rst) begin
         mq.delete();
         m_cap = 0;
         m_ovf = 1'b0;
      end else begin
         do_pop  = (mq.size() != 0) && (bus.m_ready === 1'b1);
         do_push = (bus.coef_done === 1'b1) && ((mq.size() < DEPTH) || do_pop);
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back('{ref_scale(longint'(bus.coef_in)), m_cap, (m_cap == NCOEF - 1)});
         if (bus.coef_done === 1'b1) begin
            if (!do_push) m_ovf = 1'b1;
            m_cap = (m_cap + 1) % NCOEF;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("m_valid", bus.m_valid, (mq.size() != 0));
         check("level", bus.level, mq.size());
         check("overflow", bus.overflow, m_ovf);
         if (mq.size() != 0) begin
            check("m_data", bus.m_data, mq[0].data);
            check("m_idx", bus.m_idx, mq[0].idx);
            check("m_last", bus.m_last, mq[0].last);
         end
      end
   end

   task automatic pulse(input longint v);
      bus.coef_in   = IN_W'(v);
      bus.coef_done = 1'b1;
      @(negedge clk);
      bus.coef_done = 1'b0;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.coef_done = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   longint rvals[4] = '{-6, -7, 131071, -131072};
   longint rexp[4]  = '{-1, -2, 32767, -32768};
   int     bias;

   initial begin
      bus.coef_in   = '0;
      bus.coef_done = 1'b0;
      bus.m_ready   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", bus.m_valid, 0);
      check("rst_level", bus.level, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_data", bus.m_data, 0);
      check("rst_idx", bus.m_idx, 0);
      check("rst_last", bus.m_last, 0);
      check("model_100", ref_scale(100), 25);
      check("model_m6", ref_scale(-6), -1);
      check("model_m7", ref_scale(-7), -2);
      check("model_max", ref_scale(131071), 32767);
      check("model_min", ref_scale(-131072), -32768);
      rst    = 1'b0;
      cmp_en = 1'b1;

      // Single capture with 1-cycle latency.
      bus.m_ready = 1'b1;
      pulse(100);
      check("single_valid", bus.m_valid, 1);
      check("single_data", bus.m_data, 25);
      check("single_idx", bus.m_idx, 0);
      check("single_last", bus.m_last, 0);
      @(negedge clk);
      check("single_drained", bus.m_valid, 0);
      check("single_level", bus.level, 0);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         pulse(rvals[i]);
         check("round_sat", bus.m_data, rexp[i]);
      end
      @(negedge clk);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         pulse(4 * (i + 1));
         check("frame_data", bus.m_data, i + 1);
         check("frame_idx", bus.m_idx, i);
         check("frame_last", bus.m_last, (i == 3));
      end
      @(negedge clk);

      // Backpressure: ninth pulse is dropped but still advances the frame index.
      do_reset();
      bus.m_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         pulse(4 * i);
         if (i == 7) check("bp_ovf_before", bus.overflow, 0);
      end
      check("bp_level", bus.level, 8);
      check("bp_overflow", bus.overflow, 1);
      bus.m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("bp_drain_idx", bus.m_idx, i % 4);
         @(negedge clk);
      end
      check("bp_empty", bus.m_valid, 0);
      check("bp_sticky", bus.overflow, 1);
      pulse(40);
      check("bp_next_idx", bus.m_idx, 1);
      @(negedge clk);

      // Full FIFO with simultaneous push and pop.
      do_reset();
      bus.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) pulse(4 * (i + 1));
      check("full_level", bus.level, 8);
      bus.m_ready = 1'b1;
      pulse(400);
      check("full_pp_level", bus.level, 8);
      check("full_pp_ovf", bus.overflow, 0);
      for (int i = 0; i < 8; i++) begin
         check("full_drain_data", bus.m_data, (i < 7) ? i + 2 : 100);
         @(negedge clk);
      end
      check("full_drained", bus.level, 0);

      // Reset mid-frame.
      do_reset();
      bus.m_ready = 1'b0;
      pulse(4);
      pulse(8);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", bus.m_valid, 0);
      check("mid_rst_level", bus.level, 0);
      check("mid_rst_ovf", bus.overflow, 0);
      rst         = 1'b0;
      bus.m_ready = 1'b1;
      pulse(12);
      check("mid_rst_idx", bus.m_idx, 0);
      check("mid_rst_data", bus.m_data, 3);
      @(negedge clk);

      // Random traffic with changing backpressure, checked by the compare process.
      bias = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) bias = $urandom_range(0, 100);
         rst           = ($urandom_range(0, 399) == 0);
         bus.coef_done = ($urandom_range(0, 99) < 60);
         bus.m_ready   = ($urandom_range(0, 99) < bias);
         case ($urandom_range(0, 9))
            0:       bus.coef_in = 18'sh1FFFF;
            1:       bus.coef_in = 18'sh20000;
            2:       bus.coef_in = IN_W'($urandom_range(0, 15)) - 18'sd8;
            default: bus.coef_in = IN_W'($urandom);
         endcase
         @(negedge clk);
      end
      rst           = 1'b0;
      bus.coef_done = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
